// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder for the K=3, rate-1/2 (7,5) convolutional code.
// One frame holds FRAME_BITS information bits plus TAIL_BITS zero tail symbols.
// Add-compare-select runs one symbol per cycle. Traceback then walks the
// survivors once from state 0. The decoded bits are streamed out bit 0 first.
module viterbi_decoder #(
    parameter int FRAME_BITS = 8,
    parameter int TAIL_BITS  = 2,
    parameter int METRIC_W   = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                st,
    input  logic [1:0]          code_in,
    output logic                dec_out,
    output logic                dec_valid,
    output logic                busy,
    output logic                done,
    output logic [METRIC_W-1:0] metric_out
);
    localparam int N  = FRAME_BITS + TAIL_BITS;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, ACS, TRACE, OUT} state_t;

    state_t state_reg, state_next;

    logic [CW-1:0]       cnt_reg;
    logic [1:0]          cur_reg;
    logic [METRIC_W-1:0] metric_reg;
    logic [METRIC_W-1:0] pm_reg  [4];
    logic [METRIC_W-1:0] pm_in   [4];
    logic [METRIC_W-1:0] pm_next [4];
    logic [3:0]          surv_next;

    // Survivor store: one bit per state per symbol. The array is small and is
    // read asynchronously, so traceback can take one step every cycle.
    logic [3:0] surv_mem [N];
    logic       buf_mem  [N];

    logic       last_sym;
    logic       trace_end;
    logic       out_end;
    logic [3:0] surv_rd;
    logic       surv_bit;

    assign last_sym  = (cnt_reg == CW'(N - 1));
    assign trace_end = (cnt_reg == '0);
    assign out_end   = (cnt_reg == CW'(FRAME_BITS - 1));
    assign surv_rd   = surv_mem[cnt_reg];
    assign surv_bit  = surv_rd[cur_reg];

    // ACS for each next state n = {u, s1}. Its predecessors are {n[0], x},
    // where x is the oldest bit that gets dropped. On a tie, x = 0 wins.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_acs
            localparam int U  = gi / 2;
            localparam int N0 = gi % 2;
            localparam int P0 = N0 * 2;
            localparam int P1 = N0 * 2 + 1;
            localparam logic [1:0] EXP0 = 2'(((U ^ N0) * 2) + U);
            localparam logic [1:0] EXP1 = EXP0 ^ 2'b11;
            localparam logic [METRIC_W-1:0] INIT =
                (gi == 0) ? '0 : METRIC_W'(1 << (METRIC_W - 1));

            logic [1:0]        d0, d1;
            logic [METRIC_W:0] sum0, sum1, best;
            logic              sel;

            assign pm_in[gi] = (state_reg == IDLE) ? INIT : pm_reg[gi];
            assign d0   = code_in ^ EXP0;
            assign d1   = code_in ^ EXP1;
            assign sum0 = {1'b0, pm_in[P0]} + (METRIC_W+1)'(d0[1]) + (METRIC_W+1)'(d0[0]);
            assign sum1 = {1'b0, pm_in[P1]} + (METRIC_W+1)'(d1[1]) + (METRIC_W+1)'(d1[0]);
            assign sel  = (sum1 < sum0);
            assign best = sel ? sum1 : sum0;
            assign pm_next[gi]   = best[METRIC_W] ? '1 : best[METRIC_W-1:0];
            assign surv_next[gi] = sel;
        end
    endgenerate

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    // Next-state logic and the flags that depend only on the state
    always_comb begin
        state_next = state_reg;
        busy       = 1'b1;
        dec_valid  = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (st) state_next = ACS;
            end
            ACS:   if (last_sym) state_next = TRACE;
            TRACE: if (trace_end) state_next = OUT;
            OUT: begin
                dec_valid = 1'b1;
                done      = out_end;
                if (out_end) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign dec_out    = dec_valid & buf_mem[cnt_reg];
    assign metric_out = metric_reg;

    // Counters, path metrics, traceback state and the reported final metric
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg    <= '0;
            cur_reg    <= '0;
            metric_reg <= '0;
            for (int i = 0; i < 4; i++) pm_reg[i] <= '0;
        end else begin
            case (state_reg)
                IDLE: if (st) begin
                    cnt_reg    <= CW'(1);
                    metric_reg <= '0;
                    for (int i = 0; i < 4; i++) pm_reg[i] <= pm_next[i];
                end
                ACS: begin
                    for (int i = 0; i < 4; i++) pm_reg[i] <= pm_next[i];
                    if (last_sym) begin
                        metric_reg <= pm_next[0];
                        cur_reg    <= 2'b00;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                TRACE: begin
                    cur_reg <= {cur_reg[0], surv_bit};
                    if (!trace_end) cnt_reg <= cnt_reg - CW'(1);
                end
                OUT: cnt_reg <= out_end ? '0 : cnt_reg + CW'(1);
                default: cnt_reg <= '0;
            endcase
        end
    end

    // Survivor writes during ACS and decoded-bit writes during traceback.
    // These stores are not cleared on reset.
    always_ff @(posedge clk) begin
        if ((state_reg == IDLE && st) || state_reg == ACS)
            surv_mem[cnt_reg] <= (state_reg == IDLE) ? surv_next : surv_next;
        if (state_reg == TRACE && cnt_reg < CW'(FRAME_BITS))
            buf_mem[cnt_reg] <= cur_reg[1];
    end

    // In IDLE, cnt_reg is 0, so symbol 0 lands in slot 0.
endmodule

// File: tb/tb_viterbi_decoder.sv
// Scoreboard bench for viterbi_decoder. Each frame pushes its expected bits,
// due cycles and final metric. A negedge monitor checks every output.
module tb_viterbi_decoder;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       st = 1'b0;
    logic [1:0] code_in = 2'b00;
    logic       dec_out, dec_valid, busy, done;
    logic [5:0] metric_out;

    viterbi_decoder #(.FRAME_BITS(8), .TAIL_BITS(2), .METRIC_W(6)) dut (
        .clk(clk), .rst(rst), .st(st), .code_in(code_in),
        .dec_out(dec_out), .dec_valid(dec_valid), .busy(busy),
        .done(done), .metric_out(metric_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic dbit;
        logic last;
        int   metric;
        int   due;
    } exp_t;
    exp_t sb[$];

    int compared = 0;
    int mismatched = 0;

    // Symbol 0 is the two MSBs. Decoded bit 0 is the MSB.
    localparam logic [19:0] SYM_A = 20'b11_10_00_01_01_00_10_11_00_00;
    localparam logic [19:0] SYM_B = 20'b11_10_00_00_01_00_10_11_00_00;
    localparam logic [19:0] SYM_Z = 20'b00_00_00_00_00_00_00_00_00_00;
    localparam logic [7:0]  BIT_A = 8'b1011_0100;
    localparam logic [7:0]  BIT_Z = 8'b0000_0000;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Call this #1 after a posedge. Cycle 0 of the frame is the current cycle.
    task automatic send_frame(input string name, input logic [19:0] syms, input logic [7:0] bits,
                              input int metric, input bit expect_out, input bit st_mid);
        int start;
        logic [19:0] s;
        exp_t e;
        start = cyc;
        s = syms;
        if (expect_out) begin
            for (int i = 0; i < 8; i++) begin
                e.dbit   = bits[7-i];
                e.last   = (i == 7);
                e.metric = metric;
                e.due    = start + 20 + i;
                sb.push_back(e);
            end
        end
        $display("frame %s: st at cycle %0d, expect_out=%0d metric=%0d", name, start, expect_out, metric);
        for (int t = 0; t < 10; t++) begin
            st      = (t == 0) || (st_mid && t == 5);
            code_in = s[19-2*t -: 2];
            @(posedge clk);
            #1;
        end
        st      = 1'b0;
        code_in = 2'b00;
    endtask

    // Monitor: every valid bit must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (dec_valid) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_valid: got dec_out=%0d expected no output (cycle %0d)", dec_out, cyc);
            end else begin
                e = sb.pop_front();
                $display("out cycle %0d: dec_out=%0d done=%0d exp=%0d", cyc, dec_out, done, e.dbit);
                chk("dec_out", dec_out, e.dbit);
                chk("done_pulse", done, e.last);
                chk("bit_cycle", cyc, e.due);
                if (e.last) chk("metric_out", metric_out, e.metric);
            end
        end else begin
            chk("dec_out_idle", dec_out, 0);
            chk("done_idle", done, 0);
        end
    end

    initial begin
        int s;
        int w;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", dec_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_dec_out", dec_out, 0);
        chk("rst_metric", metric_out, 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;

        // Error-free frame
        s = cyc;
        send_frame("A", SYM_A, BIT_A, 0, 1'b1, 1'b0);
        wait_until(s + 30);

        // Single symbol error
        s = cyc;
        send_frame("B", SYM_B, BIT_A, 1, 1'b1, 1'b0);
        wait_until(s + 30);

        // All-zero frame
        s = cyc;
        send_frame("Z", SYM_Z, BIT_Z, 0, 1'b1, 1'b0);
        wait_until(s + 30);

        // st pulses at cycles 5 and 15 must be ignored
        s = cyc;
        send_frame("A_stpulse", SYM_A, BIT_A, 0, 1'b1, 1'b1);
        wait_until(s + 15);
        st = 1'b1;
        @(posedge clk);
        #1;
        st = 1'b0;
        wait_until(s + 30);

        // Reset during TRACE
        s = cyc;
        send_frame("B_abort", SYM_B, BIT_A, 1, 1'b0, 1'b0);
        wait_until(s + 12);
        chk("trace_busy", busy, 1);
        chk("trace_metric", metric_out, 1);
        #2;
        rst = 1'b0;
        #1;
        $display("reset asserted at cycle %0d", cyc);
        chk("arst_busy", busy, 0);
        chk("arst_valid", dec_valid, 0);
        chk("arst_done", done, 0);
        chk("arst_dec_out", dec_out, 0);
        chk("arst_metric", metric_out, 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_idle", busy, 0);
        s = cyc;
        send_frame("A_after_rst", SYM_A, BIT_A, 0, 1'b1, 1'b0);
        wait_until(s + 30);

        // Back-to-back frames: the second st lands on the first IDLE cycle
        s = cyc;
        send_frame("A_b2b1", SYM_A, BIT_A, 0, 1'b1, 1'b0);
        wait_until(s + 28);
        send_frame("B_b2b2", SYM_B, BIT_A, 1, 1'b1, 1'b0);

        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(posedge clk);
            w++;
        end
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
